hilo_muldiv_unit: RTL and testbench

Iterative unsigned multiply/divide unit owning the HI and LO registers of the MIPS core. It sits directly downstream of the instruction decoder. It consumes the MULTU/DIVU decode (the decoder's `ToLH` qualified by Func) and the `LHToReg` select for MFLO/MFHI. It also receives the Rs/Rt register-file read data, and produces the HI/LO value fed to the register-file write-data mux. It needs WIDTH cycles per operation and raises `busy` so the datapath can stall.

---
 rtl/hilo_muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative unsigned MULTU/DIVU unit owning the HI/LO registers
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       lh_sel,
  output logic [WIDTH-1:0] lh_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             last_iter;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_neg;
  logic [WIDTH:0]   div_rem;

  // Datapath for one iteration; the extra top bit of div_diff is the borrow of the trial subtract.
  always_comb begin
    last_iter = (cnt_q == CW'(WIDTH - 1));
    mul_sum   = acc_q + ({(WIDTH+1){sreg_q[0]}} & {1'b0, mcand_q});
    div_shift = {acc_q[WIDTH-1:0], sreg_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
    div_neg   = div_diff[WIDTH+1];
    div_rem   = div_neg ? div_shift : div_diff[WIDTH:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    sreg_d  = sreg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start_mul) begin
          mcand_d = op_a;
          sreg_d  = op_b;
          acc_d   = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = MUL;
        end else if (start_div) begin
          mcand_d = op_b;
          sreg_d  = op_a;
          acc_d   = '0;
          cnt_d   = '0;
          dbz_d   = (op_b == '0);
          busy_d  = 1'b1;
          state_d = DIV;
        end
      end

      // {acc, sreg} shifts right as one 2*WIDTH register; product low bits enter from the top.
      MUL: begin
        acc_d  = {1'b0, mul_sum[WIDTH:1]};
        sreg_d = {mul_sum[0], sreg_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (last_iter) begin
          hi_d    = mul_sum[WIDTH:1];
          lo_d    = {mul_sum[0], sreg_q[WIDTH-1:1]};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      // sreg shifts dividend bits out of the top while quotient bits enter at the bottom.
      DIV: begin
        acc_d  = div_rem;
        sreg_d = {sreg_q[WIDTH-2:0], ~div_neg};
        cnt_d  = cnt_q + 1'b1;
        if (last_iter) begin
          hi_d    = div_rem[WIDTH-1:0];
          lo_d    = {sreg_q[WIDTH-2:0], ~div_neg};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      sreg_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      sreg_q  <= sreg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    lh_out = '0;
    case (lh_sel)
      2'b01:   lh_out = lo_q;
      2'b10:   lh_out = hi_q;
      default: lh_out = '0;
    endcase
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_mul, start_div;
  logic [31:0] op_a, op_b;
  logic [1:0]  lh_sel;
  logic [31:0] lh_out, hi, lo;
  logic        busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_mul(start_mul), .start_div(start_div),
    .op_a(op_a), .op_b(op_b), .lh_sel(lh_sel), .lh_out(lh_out),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an operation is a countdown of 32 edges, result from plain arithmetic.
  int          m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0, m_dbz = 1'b0;
  logic [63:0] prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (start_mul) begin
        prod = {32'd0, op_a} * {32'd0, op_b};
        p_hi = prod[63:32]; p_lo = prod[31:0];
        m_rem = 32; m_dbz = 1'b0;
      end else if (start_div) begin
        if (op_b == 0) begin
          p_lo = 32'hFFFF_FFFF; p_hi = op_a;
        end else begin
          p_lo = op_a / op_b; p_hi = op_a % op_b;
        end
        m_rem = 32; m_dbz = (op_b == 0);
      end
    end
  end

  function automatic logic [31:0] model_lh(input logic [1:0] sel);
    case (sel)
      2'b01:   return m_lo;
      2'b10:   return m_hi;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    check("cyc_hi", hi, m_hi);
    check("cyc_lo", lo, m_lo);
    check("cyc_busy", {31'd0, busy}, {31'd0, m_rem > 0});
    check("cyc_done", {31'd0, done}, {31'd0, m_done});
    check("cyc_dbz", {31'd0, div_by_zero}, {31'd0, m_dbz});
    check("cyc_lh_out", lh_out, model_lh(lh_sel));
  end

  // Drive one start cycle; returns just after the accepting edge.
  task automatic issue(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start_mul = mul; start_div = div; op_a = a; op_b = b;
    @(posedge clk); #1;
    start_mul = 1'b0; start_div = 1'b0;
  endtask

  // Counts edges until done and busy samples seen on the way, bounded by 40 edges.
  task automatic wait_done(input string name, output int lat, output int bcnt);
    bit seen = 0;
    lat = 0; bcnt = 0;
    if (busy) bcnt++;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin seen = 1; break; end
      if (busy) bcnt++;
    end
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: done not seen within 40 cycles", name);
    end
  endtask

  int lat, bcnt;

  initial begin
    rst_n = 1'b1; start_mul = 1'b0; start_div = 1'b0;
    op_a = '0; op_b = '0; lh_sel = 2'b01;
    #2 rst_n = 1'b0;
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // MULTU max * max
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mul_max", lat, bcnt);
    check("mul_max_lat", lat, 32);
    check("mul_max_busy_cycles", bcnt, 32);
    check("mul_max_hi", hi, 32'hFFFF_FFFE);
    check("mul_max_lo", lo, 32'h0000_0001);
    lh_sel = 2'b10; #1 check("mfhi", lh_out, 32'hFFFF_FFFE);
    lh_sel = 2'b01; #1 check("mflo", lh_out, 32'h0000_0001);
    lh_sel = 2'b00; #1 check("lh_00", lh_out, 32'd0);
    lh_sel = 2'b11; #1 check("lh_11", lh_out, 32'd0);
    lh_sel = 2'b01;

    // DIVU basic and large operands
    issue(1'b0, 1'b1, 32'd100, 32'd7);
    wait_done("div_100_7", lat, bcnt);
    check("div_100_7_lat", lat, 32);
    check("div_100_7_lo", lo, 32'd14);
    check("div_100_7_hi", hi, 32'd2);
    check("div_100_7_dbz", {31'd0, div_by_zero}, 32'd0);
    issue(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0001);
    wait_done("div_big", lat, bcnt);
    check("div_big_lo", lo, 32'd0);
    check("div_big_hi", hi, 32'h8000_0000);

    // Divide by zero, then multiply clears the flag
    issue(1'b0, 1'b1, 32'h1234_5678, 32'd0);
    check("dbz_set_at_accept", {31'd0, div_by_zero}, 32'd1);
    wait_done("div_zero", lat, bcnt);
    check("div_zero_lo", lo, 32'hFFFF_FFFF);
    check("div_zero_hi", hi, 32'h1234_5678);
    check("div_zero_dbz", {31'd0, div_by_zero}, 32'd1);
    issue(1'b1, 1'b0, 32'd3, 32'd5);
    check("dbz_cleared", {31'd0, div_by_zero}, 32'd0);
    wait_done("mul_3_5", lat, bcnt);
    check("mul_3_5_hi", hi, 32'd0);
    check("mul_3_5_lo", lo, 32'd15);

    // Inputs ignored while busy
    issue(1'b1, 1'b0, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    #1 start_div = 1'b1; op_a = 32'hDEAD; op_b = 32'hBEEF;
    @(posedge clk); #1 start_div = 1'b0;
    check("busy_hold_lo", lo, 32'd15);
    check("busy_hold_busy", {31'd0, busy}, 32'd1);
    wait_done("mul_6_7", lat, bcnt);
    check("mul_6_7_hi", hi, 32'd0);
    check("mul_6_7_lo", lo, 32'd42);

    // Asynchronous reset mid-operation
    issue(1'b0, 1'b1, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_lo", lo, 32'd0);
    check("arst_lh_out", lh_out, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    issue(1'b0, 1'b1, 32'd9, 32'd2);
    wait_done("div_9_2", lat, bcnt);
    check("div_9_2_lat", lat, 32);
    check("div_9_2_lo", lo, 32'd4);
    check("div_9_2_hi", hi, 32'd1);

    // Priority and back-to-back issue on the done cycle
    issue(1'b1, 1'b1, 32'd5, 32'd3);
    wait_done("prio", lat, bcnt);
    check("prio_lat", lat, 32);
    check("prio_lo", lo, 32'd15);
    check("prio_hi", hi, 32'd0);
    start_div = 1'b1; op_a = 32'd15; op_b = 32'd4;
    @(posedge clk); #1 start_div = 1'b0;
    check("b2b_accepted", {31'd0, busy}, 32'd1);
    wait_done("b2b", lat, bcnt);
    check("b2b_total_lat", lat + 33, 65);
    check("b2b_lo", lo, 32'd3);
    check("b2b_hi", hi, 32'd3);

    @(posedge clk); #1;
    check("done_single_pulse", {31'd0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
